counter_bus_if: RTL

- CPU-side bus initiator for the 3-channel counter/timer peripheral.
- Decodes word-addressed CPU reads and writes into counter_we, counter_ch and counter_val pulses.
- Reads back the free-running counter value with a stable double-sample handshake.
- Captures rising edges on the counter OUT lines into an interrupt status register and drives a maskable irq.
- Sits between the CPU data-bus mux and the counter block, in the clk domain.

---
 rtl/counter_bus_if.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/counter_bus_if.sv
// CPU-side bus initiator for the 3-channel counter/timer: register decode, channel-0 count
// readback, OUT-edge interrupt status. Define COUNTER_STABLE_READ_EN for the double-sample stable read.
module counter_bus_if #(
  parameter int unsigned RETRY_MAX = 4,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              counter_we,
  output logic [1:0]        counter_ch,
  output logic [31:0]       counter_val,
  input  logic [31:0]       counter_out,
  input  logic              counter0_OUT,
  input  logic              counter1_OUT,
  input  logic              counter2_OUT,
  output logic              irq
);

  logic [31:0] cin;
  logic [31:0] shadow1, shadow2, shadow3;
  logic [3:0]  status, status_clr;
  logic [2:0]  irq_en;
  logic [2:0]  sync1, sync2, prev, rise;
  logic [31:0] idx, rd_val;
  logic        accept, wr_go, rd_go, give_up;

  assign idx   = 32'(cpu_addr);
  assign rise  = sync2 & ~prev;
  assign wr_go = accept & cpu_wr;
  assign rd_go = accept & cpu_rd & ~cpu_wr;

`ifdef COUNTER_STABLE_READ_EN
  localparam int unsigned RW = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  typedef enum logic [1:0] {IDLE, SAMP, CMP} state_t;
  state_t        state;
  logic [31:0]   s_a;
  logic [RW-1:0] retry;

  assign accept  = (state == IDLE);
  assign give_up = (state == CMP) && (cin != s_a) && (retry == RW'(RETRY_MAX));
`else
  assign accept  = 1'b1;
  assign give_up = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (idx)
      32'd0:   rd_val = cin;
      32'd1:   rd_val = shadow1;
      32'd2:   rd_val = shadow2;
      32'd3:   rd_val = shadow3;
      32'd4:   rd_val = {28'd0, status};
      32'd5:   rd_val = {29'd0, irq_en};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    status_clr = '0;
    if (wr_go && idx == 32'd4) status_clr = cpu_wdata[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cin         <= '0;
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      shadow3     <= '0;
      status      <= '0;
      irq_en      <= '0;
      irq         <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_rdata   <= '0;
      counter_we  <= 1'b0;
      counter_ch  <= '0;
      counter_val <= '0;
`ifdef COUNTER_STABLE_READ_EN
      state       <= IDLE;
      s_a         <= '0;
      retry       <= '0;
`endif
    end else begin
      cin    <= counter_out;
      sync1  <= {counter2_OUT, counter1_OUT, counter0_OUT};
      sync2  <= sync1;
      prev   <= sync2;
      // a new edge overrides a same-cycle write-1-clear of that bit
      status <= (status & ~status_clr) | {give_up, rise};
      irq    <= |(status[2:0] & irq_en);

      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      counter_we <= 1'b0;

      if (wr_go) begin
        cpu_ready <= 1'b1;
        if (idx < 32'd4) begin
          counter_we  <= 1'b1;
          counter_ch  <= idx[1:0];
          counter_val <= cpu_wdata;
        end
        case (idx)
          32'd1:   shadow1 <= cpu_wdata;
          32'd2:   shadow2 <= cpu_wdata;
          32'd3:   shadow3 <= cpu_wdata;
          32'd5:   irq_en  <= cpu_wdata[2:0];
          default: ;
        endcase
      end else if (rd_go) begin
`ifdef COUNTER_STABLE_READ_EN
        if (idx != 32'd0) begin
          cpu_ready <= 1'b1;
          cpu_rdata <= rd_val;
        end
`else
        cpu_ready <= 1'b1;
        cpu_rdata <= rd_val;
`endif
      end

`ifdef COUNTER_STABLE_READ_EN
      case (state)
        IDLE: if (rd_go && idx == 32'd0) state <= SAMP;
        SAMP: begin
          s_a   <= cin;
          retry <= RW'(1);
          state <= CMP;
        end
        CMP: begin
          if (cin == s_a) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= s_a;
            state     <= IDLE;
          end else if (give_up) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= cin;
            state     <= IDLE;
          end else begin
            s_a   <= cin;
            retry <= retry + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule
